sequential_calculator: RTL and testbench
========================================

// Module: sequential_calculator
// PURPOSE
//  Parametrised multi-cycle integer calculator; successor to the 2-bit-opcode combinational calculator.
//  Adds REM and bitwise ops, iterative shift-add MUL and restoring DIV/REM, valid/ready handshakes
//  on both sides and a divide-by-zero flag. Sits beside the core datapath as a blocking
//  one-operation-at-a-time arithmetic unit.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range >= 2
// PORTS
//  clk         in   1        single clock; all state changes on rising edge
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        operand/opcode presented
//  in_ready    out  1        unit can accept a new operation
//  op          in   3        0 ADD,1 SUB,2 MUL,3 DIV,4 REM,5 AND,6 OR,7 XOR (all unsigned)
//  val1        in   WIDTH    operand A (dividend for DIV/REM)
//  val2        in   WIDTH    operand B (divisor for DIV/REM)
//  out_valid   out  1        result available
//  out_ready   in   1        consumer takes result
//  out         out  WIDTH    result (low WIDTH bits of product for MUL)
//  out_hi      out  WIDTH    high WIDTH bits of product for MUL; 0 for every other op
//  div_by_zero out  1        DIV/REM with val2==0; qualified by out_valid
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0 during the reset cycle, 1 the cycle after; out_valid=0;
//   out=0, out_hi=0, div_by_zero=0; iteration counter=0.
//  States: IDLE -> (accept) EXEC_MUL | EXEC_DIV | DONE; EXEC_* -> DONE when count==WIDTH-1;
//   DONE -> IDLE when out_ready.
//  Accept: in_valid & in_ready at edge T latches op, val1, val2. in_ready=1 only in IDLE.
//  ADD/SUB/AND/OR/XOR, and DIV/REM with val2==0: result computed at T, out_valid from T+1.
//  ADD/SUB wrap modulo 2^WIDTH; carry/borrow discarded.
//  MUL: shift-add, one bit/cycle, WIDTH cycles in EXEC_MUL (T+1..T+WIDTH); out_valid from T+WIDTH+1.
//   Full 2*WIDTH product = {out_hi, out}.
//  DIV/REM: restoring division, one quotient bit/cycle, same latency as MUL.
//   DIV -> quotient, REM -> remainder.
//  Divide by zero: out = all-ones for DIV, out = val1 for REM; div_by_zero=1; no iterations.
//  DONE: out, out_hi and div_by_zero held stable while out_valid & !out_ready (no change, no drop).
//   out_valid & out_ready at edge -> IDLE; in_ready=1 next cycle (no same-cycle re-accept).
//  in_valid while busy is ignored; inputs are not sampled outside IDLE.
//  rst mid-operation (EXEC_* or DONE): operation and result discarded; reset values next cycle.
//  Edge cases: MUL by 0 -> 0; max*max -> out_hi=2^WIDTH-2, out=1; DIV val1<val2 -> q=0, r=val1.
// STRUCTURE
//  Shared package calc_pkg: op encodings (OP_ADD..OP_XOR), state encoding,
//   OP_W=3 localparam.
//  Sub-module seq_divider (restoring DIV/REM core with start/done/count).
//   MUL iteration, control FSM and single-cycle ops stay in the top module.
//  Counter width $clog2(WIDTH); operands and partial results in WIDTH/2*WIDTH registers.
// TESTING
//  1 ADD 0xFFFFFFFF+1, out_ready=1 -> out=0, out_hi=0, out_valid exactly 1 cycle after accept
//  2 MUL 0xFFFFFFFF*0xFFFFFFFF -> out=0x00000001, out_hi=0xFFFFFFFE, out_valid at T+33
//  3 DIV 100/7 -> out=14; REM 100/7 -> out=2; both out_valid at T+33, div_by_zero=0
//  4 DIV 5/0 -> out=0xFFFFFFFF, div_by_zero=1; REM 5/0 -> out=5; both valid at T+1
//  5 out_ready=0 for 10 cycles after MUL 3*4 -> out=12 held stable, in_ready=0;
//    new in_valid during this time not accepted; release -> IDLE next cycle
//  6 rst at T+10 of a DIV -> next cycle out_valid=0, in_ready=1 one cycle later;
//    following SUB 3-5 -> out=0xFFFFFFFE

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator.
//   OP_W    : opcode width
//   op_t    : opcode encodings (all operations unsigned)
//   state_t : control FSM state encoding
package calc_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_REM = 3'd4,
      OP_AND = 3'd5,
      OP_OR  = 3'd6,
      OP_XOR = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EXEC_MUL = 2'd1,
      S_EXEC_DIV = 2'd2,
      S_DONE     = 2'd3
   } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin (divisor must be non-zero)
//   dividend   : numerator
//   divisor    : denominator
//   done       : high during the final iteration cycle
//   quotient   : quotient, valid while done is high
//   remainder  : remainder, valid while done is high
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CNT_W = $clog2(WIDTH);

   logic             busy;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvs_q;

   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // quo_q starts as the dividend and shifts its bits out of the top into the
   // partial remainder while quotient bits shift in at the bottom.
   // rem_q < divisor always holds, so the trial difference fits in WIDTH bits.
   always_comb begin
      shifted   = {rem_q, quo_q[WIDTH-1]};
      ge        = (shifted >= {1'b0, dvs_q});
      rem_nxt   = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      quo_nxt   = {quo_q[WIDTH-2:0], ge};
      done      = busy && (count == CNT_W'(WIDTH - 1));
      quotient  = quo_nxt;
      remainder = rem_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         count <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         count <= '0;
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
      end else if (busy) begin
         quo_q <= quo_nxt;
         rem_q <= rem_nxt;
         if (done) begin
            busy  <= 1'b0;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sequential_calculator.sv
// Multi-cycle unsigned integer calculator, one operation at a time.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid/in_ready   : operation handshake (op, val1, val2)
//   out_valid/out_ready : result handshake (out, out_hi, div_by_zero)
//   out          : result; low half of the product for MUL
//   out_hi       : high half of the product for MUL, 0 otherwise
//   div_by_zero  : DIV/REM issued with val2 == 0
//
// state      | meaning
// S_IDLE     | waiting for an operation, in_ready high
// S_EXEC_MUL | shift-add multiply, one multiplier bit per cycle
// S_EXEC_DIV | waiting on seq_divider
// S_DONE     | result held until out_ready
module sequential_calculator
   import calc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             div_by_zero
);
   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   op_t              op_q;
   logic [WIDTH-1:0] mcand;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic             div_start;
   logic             div_done;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH:0]   mul_sum;

   // During EXEC_MUL {out_hi, out} is the product register: out starts as the
   // multiplier and its LSB selects whether the multiplicand is added to the
   // upper half before the whole pair shifts right.
   always_comb begin
      accept    = in_valid && in_ready && (state == S_IDLE);
      div_start = accept && ((op_t'(op) == OP_DIV) || (op_t'(op) == OP_REM)) && (val2 != '0);
      mul_sum   = {1'b0, out_hi} + (out[0] ? {1'b0, mcand} : '0);
   end

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (val1),
      .divisor   (val2),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out         <= '0;
         out_hi      <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         op_q        <= OP_ADD;
         mcand       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  in_ready    <= 1'b0;
                  op_q        <= op_t'(op);
                  out_hi      <= '0;
                  div_by_zero <= 1'b0;
                  count       <= '0;
                  state       <= S_DONE;
                  out_valid   <= 1'b1;
                  case (op_t'(op))
                     OP_ADD: out <= val1 + val2;
                     OP_SUB: out <= val1 - val2;
                     OP_AND: out <= val1 & val2;
                     OP_OR:  out <= val1 | val2;
                     OP_XOR: out <= val1 ^ val2;
                     OP_MUL: begin
                        mcand     <= val1;
                        out       <= val2;
                        out_valid <= 1'b0;
                        state     <= S_EXEC_MUL;
                     end
                     default: begin
                        // DIV / REM
                        if (val2 == '0) begin
                           out         <= (op_t'(op) == OP_DIV) ? '1 : val1;
                           div_by_zero <= 1'b1;
                        end else begin
                           out_valid <= 1'b0;
                           state     <= S_EXEC_DIV;
                        end
                     end
                  endcase
               end else begin
                  in_ready <= 1'b1;
               end
            end
            S_EXEC_MUL: begin
               out_hi <= mul_sum[WIDTH:1];
               out    <= {mul_sum[0], out[WIDTH-1:1]};
               if (count == CNT_W'(WIDTH - 1)) begin
                  count     <= '0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            S_EXEC_DIV: begin
               if (div_done) begin
                  out       <= (op_q == OP_DIV) ? div_quo : div_rem;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequential_calculator.sv
module tb_sequential_calculator;
   import calc_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] val1 = '0;
   logic [W-1:0] val2 = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out;
   logic [W-1:0] out_hi;
   logic         div_by_zero;

   sequential_calculator #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .val1        (val1),
      .val2        (val2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out         (out),
      .out_hi      (out_hi),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      op_t          o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eo;
      logic [W-1:0] eh;
      logic         ed;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] eo;
      logic [W-1:0] eh;
      logic         ed;
      int           lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Presents an operation and returns at #1 after its accept edge.
   task automatic issue(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit push);
      int n = 0;
      @(negedge clk);
      op = o; val1 = a; val2 = b; in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("issue_in_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (push) sb.push_back(e);
   endtask

   // Waits for out_valid (out_ready low) and compares against the scoreboard head.
   task automatic wait_result(input string name);
      int   n = 0;
      exp_t e;
      while (out_valid !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_valid"}, out_valid, 1);
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         check({name, "_latency"}, n + 1, e.lat);
         check({name, "_out"}, out, e.eo);
         check({name, "_out_hi"}, out_hi, e.eh);
         check({name, "_dbz"}, div_by_zero, e.ed);
      end
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({name, "_valid_drop"}, out_valid, 0);
      check({name, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;

      vecs.push_back('{OP_ADD, 32'hFFFF_FFFF, 32'h1,        32'h0,        32'h0,        1'b0, 1});
      vecs.push_back('{OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h0,       1'b0, 1});
      vecs.push_back('{OP_SUB, 32'h3,         32'h5,        32'hFFFF_FFFE, 32'h0,        1'b0, 1});
      vecs.push_back('{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,       32'hFFFF_FFFE, 1'b0, 33});
      vecs.push_back('{OP_MUL, 32'h0,         32'h0001_2345, 32'h0,       32'h0,        1'b0, 33});
      vecs.push_back('{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,       32'h1,        1'b0, 33});
      vecs.push_back('{OP_DIV, 32'd100,       32'd7,        32'd14,       32'h0,        1'b0, 33});
      vecs.push_back('{OP_REM, 32'd100,       32'd7,        32'd2,        32'h0,        1'b0, 33});
      vecs.push_back('{OP_DIV, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'h0,       1'b1, 1});
      vecs.push_back('{OP_REM, 32'd5,         32'd0,        32'd5,        32'h0,        1'b1, 1});
      vecs.push_back('{OP_DIV, 32'd3,         32'd10,       32'd0,        32'h0,        1'b0, 33});
      vecs.push_back('{OP_REM, 32'd3,         32'd10,       32'd3,        32'h0,        1'b0, 33});
      vecs.push_back('{OP_DIV, 32'hFFFF_FFFF, 32'd10,       32'h1999_9999, 32'h0,       1'b0, 33});
      vecs.push_back('{OP_REM, 32'hFFFF_FFFF, 32'd10,       32'd5,        32'h0,        1'b0, 33});
      vecs.push_back('{OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0,      1'b0, 1});
      vecs.push_back('{OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0,      1'b0, 1});
      vecs.push_back('{OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'h0,      1'b0, 1});

      // Reset state
      @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_out_hi", out_hi, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1 check("rst_ready_after", in_ready, 1);

      // Table of single operations
      foreach (vecs[i]) begin
         e = '{vecs[i].eo, vecs[i].eh, vecs[i].ed, vecs[i].lat};
         issue(vecs[i].o, vecs[i].a, vecs[i].b, e, 1'b1);
         wait_result($sformatf("vec%0d", i));
         release_result($sformatf("vec%0d", i));
      end

      // Back-pressure: result held, new requests ignored
      issue(OP_MUL, 32'd3, 32'd4, '{32'd12, 32'h0, 1'b0, 33}, 1'b1);
      wait_result("hold_mul");
      @(negedge clk);
      op = OP_ADD; val1 = 32'd1; val2 = 32'd1; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("hold_out", out, 32'd12);
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      release_result("hold");
      repeat (3) @(posedge clk);
      #1 check("hold_no_stray", out_valid, 0);

      // Reset in the middle of a divide
      issue(OP_DIV, 32'd100, 32'd7, '{32'd14, 32'h0, 1'b0, 33}, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out", out, 0);
      rst = 1'b0;
      @(posedge clk);
      #1 check("midrst_ready_after", in_ready, 1);
      issue(OP_SUB, 32'd3, 32'd5, '{32'hFFFF_FFFE, 32'h0, 1'b0, 1}, 1'b1);
      wait_result("post_rst_sub");
      release_result("post_rst_sub");
      repeat (40) @(posedge clk);
      #1 check("post_rst_no_stray", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
